axi_r_boundary_protect: RTL

AXI_R_BOUNDARY_PROTECT -- requirements
Module: axi_r_boundary_protect

---
 rtl/axi_r_boundary_protect_pkg.sv | 22 ++
 rtl/axi_r_boundary_protect.sv | 112 +++++++++++
 2 files changed

// File: rtl/axi_r_boundary_protect_pkg.sv
// Shared definitions for the AXI read-side burst splitter/protector pair.
// Holds the FSM state encoding and the burst-info FIFO word layout
// ({final_burst, len_m1}) so the AR-side splitter and R-side protector agree.
package axi_r_boundary_protect_pkg;

  localparam int LEN_W          = 8;
  localparam int INFO_W         = 9;
  localparam int INFO_LEN_LSB   = 0;
  localparam int INFO_FINAL_BIT = LEN_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRANS = 1'b1
  } state_e;

  // One FIFO word per split burst issued on AR.
  typedef struct packed {
    logic             final_burst;  // last piece of the original request
    logic [LEN_W-1:0] len_m1;       // beats in this piece minus one
  } burst_info_t;

endpackage

// File: rtl/axi_r_boundary_protect.sv
// Purpose: re-joins split AXI read bursts into one AXIS stream, counting beats
//          locally and flagging rlast/rresp protocol errors.
// Latency: data path is combinational (0 cycles); error pulses 1 cycle after the beat.
// Backpressure: m_axi_rready follows s_axis_r_ready while in a burst; held 0 in IDLE.
// Ports: clk/rst (sync, active-high); m_axi_r* AXI R channel in; s_axis_r_* AXIS out;
//        burst_info_fifo_* burst descriptor FIFO read side; rlast_err/rresp_err pulses.
module axi_r_boundary_protect
  import axi_r_boundary_protect_pkg::*;
#(
  parameter real simulation_delay = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       s_axis_r_data,
  output logic [3:0]        s_axis_r_keep,
  output logic              s_axis_r_user,
  output logic              s_axis_r_last,
  output logic              s_axis_r_valid,
  input  logic              s_axis_r_ready,
  output logic              burst_info_fifo_ren,
  input  logic [INFO_W-1:0] burst_info_fifo_dout,
  input  logic              burst_info_fifo_empty_n,
  output logic              rlast_err,
  output logic              rresp_err
);

  // The delay only exists for behavioural models; reject nonsense values early.
  if (simulation_delay < 0.0) begin : g_bad_delay
    $error("simulation_delay must be non-negative");
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rlast_err_q, rlast_err_d;
  logic             rresp_err_q, rresp_err_d;

  burst_info_t info;
  logic        in_trans;
  logic        info_pop;
  logic        beat_acc;
  logic        beat_end;

  // FIFO dout is held from the pop until the next pop, so it stays valid
  // for the whole TRANS phase without a local copy.
  assign info     = burst_info_t'(burst_info_fifo_dout);
  assign in_trans = (state_q == ST_TRANS);
  assign info_pop = !in_trans && burst_info_fifo_empty_n;
  assign beat_end = (cnt_q == info.len_m1);

  // Handshakes are gated by registered state only, so rvalid never reaches
  // rready and s_axis_r_ready never reaches s_axis_r_valid.
  assign m_axi_rready   = in_trans && s_axis_r_ready;
  assign s_axis_r_valid = in_trans && m_axi_rvalid;
  assign beat_acc       = in_trans && m_axi_rvalid && s_axis_r_ready;

  assign s_axis_r_data       = m_axi_rdata;
  assign s_axis_r_keep       = 4'hF;
  assign s_axis_r_user       = m_axi_rresp[1];
  assign s_axis_r_last       = in_trans && info.final_burst && beat_end;
  assign burst_info_fifo_ren = !in_trans;

  assign rlast_err = rlast_err_q;
  assign rresp_err = rresp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rlast_err_d = 1'b0;
    rresp_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (info_pop) begin
          state_d = ST_TRANS;
          cnt_d   = '0;
        end
      end
      ST_TRANS: begin
        if (beat_acc) begin
          // Burst end is decided by the local count; slave rlast is only audited.
          cnt_d       = cnt_q + 1'b1;
          rlast_err_d = (m_axi_rlast != beat_end);
          rresp_err_d = m_axi_rresp[1];
          if (beat_end) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rlast_err_q <= 1'b0;
      rresp_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rlast_err_q <= rlast_err_d;
      rresp_err_q <= rresp_err_d;
    end
  end

endmodule
